// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer for the 5-to-32 one-hot decoder: walks addr through
// [FIRST_ADDR, LAST_ADDR], holding each address for DWELL cycles.
module decoder_scan_sequencer #(
    parameter int DWELL      = 4,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       hold,
    input  logic       stop,
    output logic [4:0] addr,
    output logic       addr_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] wrap_cnt
);

    localparam logic [4:0] FIRST      = 5'(FIRST_ADDR);
    localparam logic [4:0] LAST       = 5'(LAST_ADDR);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] dwell, dwell_nx;
    logic [4:0] addr_nx;
    logic       valid_nx, busy_nx, done_nx;
    logic [7:0] wrap_nx;
    logic       stop_lat, stop_nx;
    logic       mode, mode_nx;
    logic       stop_req;

    // A stop arriving in the final dwell cycle must end the scan at that boundary.
    assign stop_req = stop_lat | stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= FIRST;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap_cnt   <= 8'd0;
            dwell      <= 8'd0;
            stop_lat   <= 1'b0;
            mode       <= 1'b0;
        end else begin
            state      <= state_nx;
            addr       <= addr_nx;
            addr_valid <= valid_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            wrap_cnt   <= wrap_nx;
            dwell      <= dwell_nx;
            stop_lat   <= stop_nx;
            mode       <= mode_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        valid_nx = addr_valid;
        busy_nx  = busy;
        done_nx  = 1'b0;
        wrap_nx  = wrap_cnt;
        dwell_nx = dwell;
        stop_nx  = 1'b0;
        mode_nx  = mode;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx = SCAN;
                    addr_nx  = FIRST;
                    valid_nx = 1'b1;
                    busy_nx  = 1'b1;
                    dwell_nx = 8'd0;
                    mode_nx  = continuous;
                    wrap_nx  = 8'd0;
                end
            end
            SCAN: begin
                stop_nx = stop_req;
                if (!hold) begin
                    if (dwell == DWELL_LAST) begin
                        dwell_nx = 8'd0;
                        if (stop_req || (addr == LAST && !mode)) begin
                            state_nx = DONE;
                            valid_nx = 1'b0;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            addr_nx  = FIRST;
                            stop_nx  = 1'b0;
                        end else if (addr == LAST) begin
                            addr_nx = FIRST;
                            if (wrap_cnt != 8'hFF)
                                wrap_nx = wrap_cnt + 8'd1;
                        end else begin
                            addr_nx = addr + 5'd1;
                        end
                    end else begin
                        dwell_nx = dwell + 8'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench: three sequencer instances cover the default window,
// a small continuous window (2..5, DWELL=2) and a one-address DWELL=1 window.
module tb_decoder_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n, start, cont, hold, stop;
    logic [4:0] addr [3];
    logic [2:0] vld, busy, done;
    logic [7:0] wrap [3];

    int total = 0;
    int bad   = 0;

    decoder_scan_sequencer u0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .continuous(cont[0]),
        .hold(hold[0]), .stop(stop[0]), .addr(addr[0]), .addr_valid(vld[0]),
        .busy(busy[0]), .done(done[0]), .wrap_cnt(wrap[0])
    );

    decoder_scan_sequencer #(.DWELL(2), .FIRST_ADDR(2), .LAST_ADDR(5)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .continuous(cont[1]),
        .hold(hold[1]), .stop(stop[1]), .addr(addr[1]), .addr_valid(vld[1]),
        .busy(busy[1]), .done(done[1]), .wrap_cnt(wrap[1])
    );

    decoder_scan_sequencer #(.DWELL(1), .FIRST_ADDR(9), .LAST_ADDR(9)) u2 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]), .continuous(cont[2]),
        .hold(hold[2]), .stop(stop[2]), .addr(addr[2]), .addr_valid(vld[2]),
        .busy(busy[2]), .done(done[2]), .wrap_cnt(wrap[2])
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Packed compare: {addr, addr_valid, busy, done, wrap_cnt}
    task automatic st(input int i, input string tag, input logic [4:0] ea,
                      input logic ev, input logic eb, input logic ed, input logic [7:0] ew);
        logic [15:0] obs, exp;
        obs = {addr[i], vld[i], busy[i], done[i], wrap[i]};
        exp = {ea, ev, eb, ed, ew};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s u%0d: got addr=%0d v=%0b b=%0b d=%0b w=%0d want addr=%0d v=%0b b=%0b d=%0b w=%0d",
                   tag, i, obs[15:11], obs[10], obs[9], obs[8], obs[7:0],
                   ea, ev, eb, ed, ew);
        end
    endtask

    initial begin
        rst_n = '0; start = '0; cont = '0; hold = '0; stop = '0;
        tick(2);
        st(0, "reset", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        st(1, "reset", 5'd2, 1'b0, 1'b0, 1'b0, 8'd0);
        st(2, "reset", 5'd9, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = '1;
        tick();

        // start together with stop: stop wins
        start[0] = 1'b1; stop[0] = 1'b1;
        tick();
        start[0] = 1'b0; stop[0] = 1'b0;
        st(0, "start_stop", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        st(0, "start_stop2", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // single pass over 0..31, four cycles each
        start[0] = 1'b1; cont[0] = 1'b0;
        tick();
        start[0] = 1'b0;
        for (int a = 0; a < 32; a++)
            for (int d = 0; d < 4; d++) begin
                st(0, "single", 5'(a), 1'b1, 1'b1, 1'b0, 8'd0);
                tick();
            end
        st(0, "single_done", 5'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        st(0, "single_idle", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // hold during addr 7
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick(28);
        st(0, "hold_pre", 5'd7, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        hold[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            st(0, "hold", 5'd7, 1'b1, 1'b1, 1'b0, 8'd0);
        end
        hold[0] = 1'b0;
        tick();
        st(0, "hold_rel1", 5'd7, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        st(0, "hold_rel2", 5'd7, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        st(0, "hold_next", 5'd8, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(3);
        st(0, "addr8_end", 5'd8, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        st(0, "addr9", 5'd9, 1'b1, 1'b1, 1'b0, 8'd0);

        // start while scanning is ignored
        start[0] = 1'b1; cont[0] = 1'b1;
        tick();
        start[0] = 1'b0; cont[0] = 1'b0;
        st(0, "start_ign", 5'd9, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(2);
        st(0, "start_ign2", 5'd9, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        st(0, "start_ign3", 5'd10, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(8);
        st(0, "pre_rst", 5'd12, 1'b1, 1'b1, 1'b0, 8'd0);

        // reset mid-scan aborts without done
        rst_n[0] = 1'b0;
        tick();
        st(0, "rst_mid", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n[0] = 1'b1;
        tick();
        st(0, "rst_after", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // continuous 2..5, DWELL=2, stop mid-dwell of addr 3 in pass 3
        start[1] = 1'b1; cont[1] = 1'b1;
        tick();
        start[1] = 1'b0; cont[1] = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int a = 2; a < 6; a++)
                for (int d = 0; d < 2; d++) begin
                    st(1, "cont", 5'(a), 1'b1, 1'b1, 1'b0, 8'(p));
                    tick();
                end
        st(1, "p3_a2", 5'd2, 1'b1, 1'b1, 1'b0, 8'd2);
        tick(2);
        st(1, "p3_a3", 5'd3, 1'b1, 1'b1, 1'b0, 8'd2);
        stop[1] = 1'b1;
        tick();
        stop[1] = 1'b0;
        st(1, "stop_lat", 5'd3, 1'b1, 1'b1, 1'b0, 8'd2);
        tick();
        st(1, "stop_done", 5'd2, 1'b0, 1'b0, 1'b1, 8'd2);
        tick();
        st(1, "stop_idle", 5'd2, 1'b0, 1'b0, 1'b0, 8'd2);

        // stop in the final dwell cycle ends at that boundary
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        st(1, "fs_start", 5'd2, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        stop[1] = 1'b1;
        tick();
        stop[1] = 1'b0;
        st(1, "final_stop", 5'd2, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        st(1, "final_idle", 5'd2, 1'b0, 1'b0, 1'b0, 8'd0);

        // DWELL=1, single address 9: wrap every cycle, saturating
        start[2] = 1'b1; cont[2] = 1'b1;
        tick();
        start[2] = 1'b0; cont[2] = 1'b0;
        st(2, "d1_start", 5'd9, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int k = 1; k <= 260; k++) begin
            tick();
            st(2, "d1_wrap", 5'd9, 1'b1, 1'b1, 1'b0, (k > 255) ? 8'd255 : 8'(k));
        end
        stop[2] = 1'b1;
        tick();
        stop[2] = 1'b0;
        st(2, "d1_stop", 5'd9, 1'b0, 1'b0, 1'b1, 8'd255);
        tick();
        st(2, "d1_idle", 5'd9, 1'b0, 1'b0, 1'b0, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Generates the 5-bit select address and enable that drive the 5-to-32 one-hot decoder stage, stepping through a programmable address window.
- Each address is held for a fixed dwell time.
- Supports single-pass and continuous (wrap-around) scanning, a pause input, and a graceful stop.
- Sits directly upstream of the decoder; its addr/addr_valid outputs feed the decoder's select and enable inputs.

Parameters:
DWELL, 4, clock cycles each address is held (legal 1..255).
FIRST_ADDR, 0, first address of the scan window (0..31).
LAST_ADDR, 31, last address of the scan window (FIRST_ADDR..31).

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  reset, synchronous and active-low.
start  input  1  begin a scan (sampled only in IDLE).
continuous  input  1  sampled with start; 1 = wrap forever, 0 = single pass.
hold  input  1  pauses dwell counting while high; addr is held.
stop  input  1  request termination at end of the current dwell.
addr  output  5  current select address to the decoder.
addr_valid  output  1  decoder enable; high only in SCAN.
busy  output  1  high in SCAN.
done  output  1  one-cycle pulse when a scan terminates.
wrap_cnt  output  8  completed passes in continuous mode; saturates at 255.

Behaviour:
- Reset values (clk edge with rst_n=0): state=IDLE, addr=FIRST_ADDR, addr_valid=0, busy=0, done=0, wrap_cnt=0, dwell counter=0, stop latch=0, mode=0. Reset mid-scan aborts immediately; no done pulse.
- All outputs are registered.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 and stop=0 -> SCAN next cycle: addr=FIRST_ADDR, addr_valid=1, busy=1, dwell=0, mode latched from continuous, wrap_cnt cleared.
  - start and stop together -> stay IDLE (stop wins).
- SCAN:
  - If hold=1, the dwell counter and addr freeze.
  - Otherwise dwell increments. When dwell==DWELL-1 and hold=0 (end of dwell):
    - If addr!=LAST_ADDR and no stop latched: addr+1, dwell=0.
    - If addr==LAST_ADDR, mode=continuous and no stop latched: addr=FIRST_ADDR, dwell=0, wrap_cnt+1 (saturating at 255).
    - If addr==LAST_ADDR and mode=single, or a stop is latched: -> DONE; addr_valid=0, busy=0 in the same edge.
- Stop handling:
  - stop is latched on any SCAN cycle and cleared on leaving SCAN.
  - stop asserted during the final dwell cycle takes effect at that same boundary.
- Each address is presented for exactly DWELL consecutive cycles of addr_valid=1 (plus any hold cycles).
- No gap cycle between consecutive addresses; the addr change and dwell reset occur on the same edge.
- DONE: done=1 for exactly one cycle, addr returns to FIRST_ADDR, then -> IDLE. start is ignored in DONE.
- start asserted in SCAN is ignored; continuous is ignored outside the start cycle.
- DWELL=1: a new address every non-hold cycle.
- FIRST_ADDR==LAST_ADDR: a single address, re-dwelled each pass in continuous mode.
- addr never leaves [FIRST_ADDR, LAST_ADDR] while addr_valid=1.
- Latency: start at edge N -> addr_valid=1 with addr=FIRST_ADDR visible after edge N+1.

Test Plan:
1. Defaults, single pass: start=1, continuous=0 for 1 cycle -> addr 0..31, each held 4 cycles with addr_valid=1 (128 cycles total); then done pulses 1 cycle; busy=0; wrap_cnt=0.
2. Continuous with stop: FIRST_ADDR=2, LAST_ADDR=5, DWELL=2, continuous=1 -> sequence 2,3,4,5,2,... with wrap_cnt incrementing on each 5->2; stop pulsed mid-dwell of addr 3 in pass 3 -> addr 3 completes its dwell, then done; wrap_cnt=2.
3. Hold: hold high for 10 cycles during the dwell of addr 7 -> addr stays 7 for 4+10 cycles; the next address is 8; no skipped or repeated addresses.
4. Simultaneous start and stop in IDLE -> stays IDLE, addr_valid=0, no done. start during SCAN -> ignored; the sequence is unchanged.
5. Reset mid-scan: rst_n=0 at addr 12 -> next cycle addr=0, addr_valid=0, busy=0, done=0, wrap_cnt=0.
6. DWELL=1 with FIRST_ADDR=LAST_ADDR=9 in continuous mode -> addr constant at 9, addr_valid=1, wrap_cnt increments every cycle and saturates at 255.
